// File: rtl/reg_bank.sv
// -----------------------------------------------------------------------------
// reg_bank
//
// Purpose:
//   Small register file of DEPTH words, each WIDTH bits wide, with a valid
//   flag per entry. Writes are byte-lane masked. A synchronous bulk clear wipes
//   every entry and valid flag. Two independent read ports (A and B) return the
//   addressed word and its valid flag one cycle after a read request.
//
// Configuration macro:
//   REG_BANK_BYPASS_EN - when defined, a read that targets the same in-range
//                        address as an accepted same-cycle write returns the
//                        merged (post-write) word and valid flag. When left
//                        undefined, such a read returns the old contents. The
//                        storage update is identical in both builds.
//
// Parameters:
//   WIDTH - word width in bits (multiple of 8)
//   DEPTH - number of entries (2 <= DEPTH <= 2**AW)
//   AW    - address width in bits
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-low (clears storage and outputs)
//   wrt        in   write enable
//   clr        in   synchronous clear of all entries (beats a same-cycle write)
//   wr_addr    in   write address (addresses >= DEPTH are ignored)
//   wr_be      in   byte-lane enables, bit i covers data_in[8i+7:8i]
//   data_in    in   write data
//   rd_en_a    in   port A read request
//   rd_addr_a  in   port A read address
//   data_out_a out  port A registered read data
//   valid_a    out  port A registered valid flag
//   rd_en_b    in   port B read request
//   rd_addr_b  in   port B read address
//   data_out_b out  port B registered read data
//   valid_b    out  port B registered valid flag
// -----------------------------------------------------------------------------
module reg_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrt,
  input  logic               clr,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH/8-1:0] wr_be,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               rd_en_a,
  input  logic [AW-1:0]      rd_addr_a,
  output logic [WIDTH-1:0]   data_out_a,
  output logic               valid_a,
  input  logic               rd_en_b,
  input  logic [AW-1:0]      rd_addr_b,
  output logic [WIDTH-1:0]   data_out_b,
  output logic               valid_b
);

  localparam int NB = WIDTH / 8;
  localparam int NP = 2;  // number of read ports

  // Storage. Flops rather than RAM: the bulk clear touches every entry at once.
  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [DEPTH-1:0]            r_valid;

  // Next-state storage computed per entry.
  logic [DEPTH-1:0][WIDTH-1:0] w_mem_next;
  logic [DEPTH-1:0]            w_valid_next;

  // Per-entry write select, byte-lane mask expanded to bit level.
  logic [DEPTH-1:0]            w_wr_sel;
  logic [WIDTH-1:0]            w_lane_mask;
  logic                        w_wr_any_lane;

  // Read-port views indexed by port number (0 = A, 1 = B).
  logic [NP-1:0][AW-1:0]       w_rd_addr;
  logic [NP-1:0][WIDTH-1:0]    w_rd_word;
  logic [NP-1:0]               w_rd_vld;

  // Registered read outputs.
  logic [WIDTH-1:0]            r_data_a;
  logic                        r_valid_a;
  logic [WIDTH-1:0]            r_data_b;
  logic                        r_valid_b;

  assign w_wr_any_lane = |wr_be;
  assign w_rd_addr[0]  = rd_addr_a;
  assign w_rd_addr[1]  = rd_addr_b;

  // ---------------------------------------------------------------------------
  // Byte-lane mask: each wr_be bit fans out to its 8 data bits.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : gen_lane
      assign w_lane_mask[gi*8 +: 8] = {8{wr_be[gi]}};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Write decode and per-entry next state. Only indices 0..DEPTH-1 exist, so
  // an out-of-range wr_addr selects nothing and the write is silently dropped.
  // clr squashes the select so a colliding write never lands.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
      assign w_wr_sel[gi] = wrt && !clr && (wr_addr == AW'(gi));

      assign w_mem_next[gi] = w_wr_sel[gi]
                            ? ((data_in & w_lane_mask) | (r_mem[gi] & ~w_lane_mask))
                            : r_mem[gi];

      // A write with no lanes enabled leaves the valid flag alone.
      assign w_valid_next[gi] = r_valid[gi] | (w_wr_sel[gi] & w_wr_any_lane);
    end
  endgenerate

`ifdef REG_BANK_BYPASS_EN
  // A write is accepted only when it hits an existing entry and is not
  // squashed by clr; only accepted writes are forwarded to the read ports.
  logic w_wr_accept;
  assign w_wr_accept = |w_wr_sel;
`endif

  // ---------------------------------------------------------------------------
  // Read ports. Each port decodes its address against the stored entries; an
  // address that matches no entry yields zero data and a clear valid flag.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NP; gi++) begin : gen_port
      logic [WIDTH-1:0] w_word;
      logic             w_vld;

      always_comb begin
        w_word = '0;
        w_vld  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
          if (w_rd_addr[gi] == AW'(k)) begin
            w_word = r_mem[k];
            w_vld  = r_valid[k];
          end
        end
      end

`ifdef REG_BANK_BYPASS_EN
      // Forward the post-write image when this port reads the entry being
      // written: enabled lanes from data_in, the rest from the stored word.
      logic w_byp;
      assign w_byp = w_wr_accept && (wr_addr == w_rd_addr[gi]);

      assign w_rd_word[gi] = w_byp
                           ? ((data_in & w_lane_mask) | (w_word & ~w_lane_mask))
                           : w_word;
      assign w_rd_vld[gi]  = w_vld | (w_byp & w_wr_any_lane);
`else
      // Reads always see the contents as they stood before this edge.
      assign w_rd_word[gi] = w_word;
      assign w_rd_vld[gi]  = w_vld;
`endif
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State update. Reset clears storage and read outputs; clr clears storage
  // only, so a read issued alongside clr still delivers pre-clear data and
  // earlier read results survive the clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem     <= '0;
      r_valid   <= '0;
      r_data_a  <= '0;
      r_valid_a <= 1'b0;
      r_data_b  <= '0;
      r_valid_b <= 1'b0;
    end else begin
      if (clr) begin
        r_mem   <= '0;
        r_valid <= '0;
      end else begin
        r_mem   <= w_mem_next;
        r_valid <= w_valid_next;
      end

      if (rd_en_a) begin
        r_data_a  <= w_rd_word[0];
        r_valid_a <= w_rd_vld[0];
      end

      if (rd_en_b) begin
        r_data_b  <= w_rd_word[1];
        r_valid_b <= w_rd_vld[1];
      end
    end
  end

  assign data_out_a = r_data_a;
  assign valid_a    = r_valid_a;
  assign data_out_b = r_data_b;
  assign valid_b    = r_valid_b;

endmodule
